dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port dmem between two requesters: port 0 (pipeline
//   mem/branch stage) and port 1 (program loader / debug port).
//   - Grants one access per cycle.
//   - Routes synchronous read data back to the requester that issued the read.
//   - Bounds starvation of port 1.
//   - Supports locked port-1 bursts for program loading.
//   - Sits between mem_branch (word_encdec output side) and the dmem instance.
// PARAMETERS
//   ADDR_W       11  word-address width (dmem addr = byte addr[12:2])
//   DATA_W       32  data word width
//   STARVE_LIMIT 4   cycles port 1 may wait before a forced grant (>=1)
//   MAX_BURST    8   max consecutive locked port-1 grants (>=1)
// PORTS
//   clk         in   1       clock; all state on rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   p0_req      in   1       port 0 access request
//   p0_read     in   1       port 0 read
//   p0_writeb   in   4       port 0 byte write enables
//   p0_addr     in   ADDR_W  port 0 word address
//   p0_wdata    in   DATA_W  port 0 write data
//   p0_gnt      out  1       port 0 granted this cycle (comb.); pipeline stalls on req&~gnt
//   p0_rvalid   out  1       port 0 read data valid
//   p0_rdata    out  DATA_W  port 0 read data
//   p1_req, p1_read, p1_writeb, p1_addr, p1_wdata   in    same as port 0
//   p1_lock     in   1       hold grant for back-to-back port-1 accesses
//   p1_gnt, p1_rvalid, p1_rdata                     out   same as port 0
//   mem_read    out  1       dmem read strobe
//   mem_writeb  out  4       dmem byte write enables
//   mem_addr    out  ADDR_W  dmem word address
//   mem_wdata   out  DATA_W  dmem write data
//   mem_rdata   in   DATA_W  dmem read data, valid 1 cycle after mem_read
// BEHAVIOUR
//   Reset (rst_n low, async):
//   - state=PRIO_P0; starve_cnt=0; burst_cnt=0; rd_pend=0.
//   - All outputs 0: gnt, rvalid, mem_read and mem_writeb are gated by rst_n.
//   - A read in flight at reset is discarded; no rvalid follows release.
//   Grant (combinational, same cycle as req):
//   - PRIO_P0: p0 wins if p0_req, unless starve_cnt==STARVE_LIMIT, in which
//     case p1 wins. p1 wins if p0_req=0.
//   - P1_LOCK: p1 wins whenever p1_req; p0_gnt=0.
//   - Exactly one of p0_gnt/p1_gnt may be 1; both are 0 if no req.
//   Mux:
//   - mem_* come from the granted port.
//   - mem_writeb=0 and mem_read=0 when nothing is granted.
//   - mem_read = read & (writeb==0): a write takes precedence over a
//     read-and-write request.
//   - A granted request with read=0 and writeb=0 is a no-op.
//   Read return:
//   - Registered rd_pend/rd_owner are set on a granted read.
//   - Next cycle: the owner's rvalid=1 and both rdata=mem_rdata.
//   - Latency is 1 cycle; back-to-back reads are pipelined with no bubble.
//   - Ownership may switch each cycle.
//   Starvation counter:
//   - starve_cnt++ on p1_req & ~p1_gnt, saturating at STARVE_LIMIT.
//   - Cleared on p1_gnt or on ~p1_req.
//   FSM:
//   - PRIO_P0 -> P1_LOCK on p1_gnt & p1_lock; burst_cnt=1.
//   - P1_LOCK: each p1 grant does burst_cnt++.
//   - P1_LOCK -> PRIO_P0 on ~p1_lock, ~p1_req, or a grant made with
//     burst_cnt==MAX_BURST. That last grant is still serviced.
//   - On exit, starve_cnt=0. p0 gets at least one grant before p1 can lock
//     again if p0_req is pending.
//   Simultaneous events:
//   - A p1 forced grant overrides p0 for exactly one cycle, then the counter
//     clears.
//   - Lock exit and a new p1_lock in the same cycle: p0 is served first.
// STRUCTURE
//   Package dmem_arb_pkg holds:
//   - state enum {PRIO_P0, P1_LOCK};
//   - OWNER_P0/OWNER_P1 constants;
//   - the request struct {read, writeb, addr, wdata}.
//   Sub-module dmem_arb_prio holds the combinational grant decision (state,
//   reqs, starve flag -> gnts). Counters, FSM, mux and return path stay
//   in the top.
// TESTING
//   1. p0 read addr 0x010 only -> p0_gnt same cycle; next cycle
//      p0_rvalid=1, p0_rdata=mem[0x010]; p1_rvalid=0.
//   2. p0_req held high, p1 write 0xDEADBEEF @0x020 -> p1_gnt exactly at
//      wait cycle 5 (STARVE_LIMIT=4); mem[0x020] updated; p0 resumes next cycle.
//   3. Idle p0, p1_lock=1 with 10 writes -> 8 contiguous grants, then
//      PRIO_P0 for 1 cycle with p0_req pending (p0 granted), then the
//      remaining 2 are granted.
//   4. Alternating grants: p1 read @0x005, then p0 read @0x006 -> p1_rvalid
//      then p0_rvalid on consecutive cycles with the correct data; never both.
//   5. rst_n low the cycle after a granted read -> no rvalid after release;
//      state PRIO_P0; all outputs 0 during reset.
//   6. p0 read=1 with writeb=4'b0011 -> mem_read=0, bytes 0-1 written,
//      no p0_rvalid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port dmem arbiter.
// Request bundle widths match the default dmem geometry (2K words x 32 bits).
package dmem_arb_pkg;

    localparam int REQ_ADDR_W = 11;
    localparam int REQ_DATA_W = 32;

    typedef enum logic {
        PRIO_P0 = 1'b0,
        P1_LOCK = 1'b1
    } arb_state_t;

    localparam logic OWNER_P0 = 1'b0;
    localparam logic OWNER_P1 = 1'b1;

    typedef struct packed {
        logic                  read;
        logic [3:0]            writeb;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Combinational grant decision: p0 has priority unless p1 is starved or
// holds a locked burst. At most one winner per cycle.
module dmem_arb_prio
    import dmem_arb_pkg::*;
(
    input  arb_state_t state,
    input  logic       p0_req,
    input  logic       p1_req,
    input  logic       starve,
    output logic       p0_win,
    output logic       p1_win
);

    always_comb begin
        p0_win = 1'b0;
        p1_win = 1'b0;
        if (state == P1_LOCK) begin
            p1_win = p1_req;
        end else if (p1_req && (!p0_req || starve)) begin
            p1_win = 1'b1;
        end else begin
            p0_win = p0_req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port dmem: grant, request mux,
// 1-cycle read-return routing, starvation bound and locked port-1 bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = REQ_ADDR_W,
    parameter int DATA_W       = REQ_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_read,
    input  logic [3:0]        p0_writeb,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_read,
    input  logic [3:0]        p1_writeb,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic [3:0]        mem_writeb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    arb_state_t      state;
    logic [SC_W-1:0] starve_cnt;
    logic [BC_W-1:0] burst_cnt;
    logic            rd_pend;
    logic            rd_owner;
    logic            starve;
    logic            p0_win;
    logic            p1_win;
    mem_req_t        req0;
    mem_req_t        req1;
    mem_req_t        sel;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v == SC_W'(STARVE_LIMIT)) ? v : v + SC_W'(1);
    endfunction

    assign starve = (starve_cnt == SC_W'(STARVE_LIMIT));

    dmem_arb_prio u_prio (
        .state  (state),
        .p0_req (p0_req),
        .p1_req (p1_req),
        .starve (starve),
        .p0_win (p0_win),
        .p1_win (p1_win)
    );

    // Grants are forced low while reset is held so the dmem sees no access.
    assign p0_gnt = rst_n & p0_win;
    assign p1_gnt = rst_n & p1_win;

    assign req0 = '{read: p0_read, writeb: p0_writeb,
                    addr: REQ_ADDR_W'(p0_addr), wdata: REQ_DATA_W'(p0_wdata)};
    assign req1 = '{read: p1_read, writeb: p1_writeb,
                    addr: REQ_ADDR_W'(p1_addr), wdata: REQ_DATA_W'(p1_wdata)};

    always_comb begin
        sel = '0;
        if (p0_gnt) begin
            sel = req0;
        end else if (p1_gnt) begin
            sel = req1;
        end
    end

    // Any byte enable turns a read-and-write request into a plain write.
    assign mem_read   = sel.read & (sel.writeb == 4'b0000);
    assign mem_writeb = sel.writeb;
    assign mem_addr   = ADDR_W'(sel.addr);
    assign mem_wdata  = DATA_W'(sel.wdata);

    assign p0_rvalid = rst_n & rd_pend & (rd_owner == OWNER_P0);
    assign p1_rvalid = rst_n & rd_pend & (rd_owner == OWNER_P1);
    assign p0_rdata  = rst_n ? mem_rdata : '0;
    assign p1_rdata  = rst_n ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PRIO_P0;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= OWNER_P0;
        end else begin
            rd_pend  <= mem_read;
            rd_owner <= p1_gnt ? OWNER_P1 : OWNER_P0;

            if (p1_gnt || !p1_req) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= sat_inc(starve_cnt);
            end

            case (state)
                PRIO_P0: begin
                    if (p1_gnt && p1_lock && (MAX_BURST > 1)) begin
                        state     <= P1_LOCK;
                        burst_cnt <= BC_W'(1);
                    end
                end
                P1_LOCK: begin
                    // The grant that completes the burst is still serviced this cycle.
                    if (!p1_req || !p1_lock || (burst_cnt == BC_W'(MAX_BURST - 1))) begin
                        state      <= PRIO_P0;
                        burst_cnt  <= '0;
                        starve_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + BC_W'(1);
                    end
                end
                default: state <= PRIO_P0;
            endcase
        end
    end

endmodule
